smi_frame_arbiter_xn: RTL and testbench

- N-way SMI frame arbiter with parametrised channel count, flit width and arbitration mode.
- Frames are granted atomically: no interleaving of flits from different channels.
- Adds a multi-frame burst grant, a registered output stage and optional channel-ID tag insertion.
- Sits between the per-channel request frame assemblers and the single downstream request port of N-way transaction arbiters.

---
 rtl/smi_frame_arbiter_xn.sv | 200 ++++++++++++++++++++
 tb/tb_smi_frame_arbiter_xn.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_frame_arbiter_xn.sv
// smi_frame_arbiter_xn
// N-way SMI frame arbiter. A granted channel keeps the output until its frame
// (or its burst of up to FramesPerGrant frames) completes, so flits from
// different channels never interleave. Output flits pass through a one-entry
// holding register. Arbitration is round-robin or fixed priority (ArbMode).
// Optional feature macro: SMI_ARB_TAG_INSERT_EN -- when defined, bits [31:26]
// of the first flit of each frame carry the granted channel index.
module smi_frame_arbiter_xn #(
  parameter int FlitWidth      = 4,
  parameter int NumChannels    = 4,
  parameter int ArbMode        = 0,
  parameter int FramesPerGrant = 1,
  parameter int DataWidth      = FlitWidth * 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NumChannels-1:0]           smiReqInReady,
  input  logic [8*NumChannels-1:0]         smiReqInEofc,
  input  logic [DataWidth*NumChannels-1:0] smiReqInData,
  output logic [NumChannels-1:0]           smiReqInStop,
  output logic                             smiReqOutReady,
  output logic [7:0]                       smiReqOutEofc,
  output logic [DataWidth-1:0]             smiReqOutData,
  input  logic                             smiReqOutStop,
  output logic [3:0]                       grantIdx
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StForward = 2'd1,
    StHold    = 2'd2
  } state_e;

  localparam logic [3:0] LastChan = 4'(NumChannels - 1);
  localparam logic [3:0] BurstMax = 4'(FramesPerGrant);

  logic                 rstSync_q;
  state_e               state_q, state_d;
  logic [3:0]           grant_q, grant_d;
  logic [3:0]           ptr_q, ptr_d;
  logic [3:0]           burst_q, burst_d;
  logic                 outReady_q;
  logic [7:0]           outEofc_q;
  logic [DataWidth-1:0] outData_q;

  logic                 selReady;
  logic [7:0]           selEofc;
  logic [DataWidth-1:0] selData;
  logic [DataWidth-1:0] loadData;
  logic                 found;
  logic [3:0]           winIdx;
  logic [3:0]           nextPtr;
  logic [3:0]           burstInc;
  logic                 outBlocked;
  logic                 outXfer;
  logic                 load;

  // Reset asserts asynchronously but its release is retimed to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rstSync_q <= 1'b0;
    else        rstSync_q <= 1'b1;
  end

  // Pick out the granted channel's flit
  always_comb begin
    selReady = 1'b0;
    selEofc  = '0;
    selData  = '0;
    for (int i = 0; i < NumChannels; i++) begin
      if (grant_q == 4'(i)) begin
        selReady = smiReqInReady[i];
        selEofc  = smiReqInEofc[8*i +: 8];
        selData  = smiReqInData[DataWidth*i +: DataWidth];
      end
    end
  end

  // Winner search: scan from the pointer (round-robin) or from index 0 (fixed)
  always_comb begin
    found  = 1'b0;
    winIdx = '0;
    for (int k = 0; k < NumChannels; k++) begin
      for (int j = 0; j < NumChannels; j++) begin
        if (!found && smiReqInReady[j] &&
            ((ArbMode != 0) ? (j == k) : (j == (int'(ptr_q) + k) % NumChannels))) begin
          found  = 1'b1;
          winIdx = 4'(j);
        end
      end
    end
  end

  assign nextPtr    = (grant_q == LastChan) ? 4'd0 : grant_q + 4'd1;
  assign burstInc   = burst_q + 4'd1;
  assign outBlocked = outReady_q && smiReqOutStop;
  assign outXfer    = outReady_q && !smiReqOutStop;
  assign load       = (state_q == StForward) && selReady && !outBlocked;

  // Only the granted channel may be released, and only while forwarding
  always_comb begin
    for (int i = 0; i < NumChannels; i++) begin
      smiReqInStop[i] = (grant_q == 4'(i)) ? ((state_q != StForward) || outBlocked) : 1'b1;
    end
  end

`ifdef SMI_ARB_TAG_INSERT_EN
  logic firstFlit_q;

  // Track whether the next accepted flit starts a frame
  always_ff @(posedge clk or negedge rstSync_q) begin
    if (!rstSync_q)                     firstFlit_q <= 1'b0;
    else if (state_q == StIdle && found) firstFlit_q <= 1'b1;
    else if (load)                      firstFlit_q <= (selEofc != 8'd0);
  end

  // Stamp the channel index into the top bits of a frame's first flit
  always_comb begin
    loadData = selData;
    if (firstFlit_q) loadData[31:26] = {2'b00, grant_q};
  end
`else
  // Data passes through untouched
  always_comb begin
    loadData = selData;
  end
`endif

  // Arbitration FSM next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = winIdx;
          burst_d = '0;
          state_d = StForward;
        end
      end
      StForward: begin
        if (load && (selEofc != 8'd0)) begin
          burst_d = burstInc;
          if (burstInc == BurstMax) begin
            ptr_d   = nextPtr;
            state_d = StIdle;
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (selReady) begin
          state_d = StForward;
        end else begin
          ptr_d   = nextPtr;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, grant, pointer and burst count registers
  always_ff @(posedge clk or negedge rstSync_q) begin
    if (!rstSync_q) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  // Output holding register: reload on accept, empty when drained
  always_ff @(posedge clk or negedge rstSync_q) begin
    if (!rstSync_q) begin
      outReady_q <= 1'b0;
      outEofc_q  <= '0;
      outData_q  <= '0;
    end else if (load) begin
      outReady_q <= 1'b1;
      outEofc_q  <= selEofc;
      outData_q  <= loadData;
    end else if (outXfer) begin
      outReady_q <= 1'b0;
    end
  end

  assign smiReqOutReady = outReady_q;
  assign smiReqOutEofc  = outEofc_q;
  assign smiReqOutData  = outData_q;
  assign grantIdx       = grant_q;

endmodule

// File: tb/tb_smi_frame_arbiter_xn.sv
// tb_smi_frame_arbiter_xn
// Directed bench for smi_frame_arbiter_xn. Three instances share the inputs:
// round-robin/1 frame, round-robin/3 frames, fixed priority/1 frame. Each test
// resets and drives one of them through per-channel flit source queues.
// Honours SMI_ARB_TAG_INSERT_EN when it is defined for the build.
module tb_smi_frame_arbiter_xn;

  localparam int NC = 4;
  localparam int DW = 32;
`ifdef SMI_ARB_TAG_INSERT_EN
  localparam bit TagEn = 1'b1;
`else
  localparam bit TagEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NC-1:0]    inReady;
  logic [8*NC-1:0]  inEofc;
  logic [DW*NC-1:0] inData;
  logic             outStop;

  logic [NC-1:0] stop0, stop1, stop2;
  logic          outReady0, outReady1, outReady2;
  logic [7:0]    outEofc0, outEofc1, outEofc2;
  logic [DW-1:0] outData0, outData1, outData2;
  logic [3:0]    grant0, grant1, grant2;

  logic [NC-1:0] curStop;
  logic          curOutReady;
  logic [7:0]    curOutEofc;
  logic [DW-1:0] curOutData;
  logic [3:0]    curGrant;

  int            activeDut;
  int            checks;
  int            failures;
  int            cycleNo;
  logic          outStopNext;
  logic [NC-1:0] chEn;

  logic [31:0] qData[NC][$];
  logic [7:0]  qEofc[NC][$];
  logic [31:0] obsData[$];
  logic [7:0]  obsEofc[$];
  int          obsCyc[$];
  logic [31:0] expD[$];
  logic [7:0]  expE[$];

  smi_frame_arbiter_xn #(.FlitWidth(4), .NumChannels(NC), .ArbMode(0), .FramesPerGrant(1)) dutRr (
    .clk(clk), .rst_n(rst_n), .smiReqInReady(inReady), .smiReqInEofc(inEofc),
    .smiReqInData(inData), .smiReqInStop(stop0), .smiReqOutReady(outReady0),
    .smiReqOutEofc(outEofc0), .smiReqOutData(outData0), .smiReqOutStop(outStop),
    .grantIdx(grant0));

  smi_frame_arbiter_xn #(.FlitWidth(4), .NumChannels(NC), .ArbMode(0), .FramesPerGrant(3)) dutBurst (
    .clk(clk), .rst_n(rst_n), .smiReqInReady(inReady), .smiReqInEofc(inEofc),
    .smiReqInData(inData), .smiReqInStop(stop1), .smiReqOutReady(outReady1),
    .smiReqOutEofc(outEofc1), .smiReqOutData(outData1), .smiReqOutStop(outStop),
    .grantIdx(grant1));

  smi_frame_arbiter_xn #(.FlitWidth(4), .NumChannels(NC), .ArbMode(1), .FramesPerGrant(1)) dutFp (
    .clk(clk), .rst_n(rst_n), .smiReqInReady(inReady), .smiReqInEofc(inEofc),
    .smiReqInData(inData), .smiReqInStop(stop2), .smiReqOutReady(outReady2),
    .smiReqOutEofc(outEofc2), .smiReqOutData(outData2), .smiReqOutStop(outStop),
    .grantIdx(grant2));

  // Free-running 10ns clock
  always #5 clk = ~clk;

  // Route the instance under test to common observation signals
  always_comb begin
    curStop     = stop0;
    curOutReady = outReady0;
    curOutEofc  = outEofc0;
    curOutData  = outData0;
    curGrant    = grant0;
    if (activeDut == 1) begin
      curStop = stop1; curOutReady = outReady1; curOutEofc = outEofc1;
      curOutData = outData1; curGrant = grant1;
    end else if (activeDut == 2) begin
      curStop = stop2; curOutReady = outReady2; curOutEofc = outEofc2;
      curOutData = outData2; curGrant = grant2;
    end
  end

  function automatic logic [31:0] payload(input int ch, input int fr, input int fl);
    return 32'((ch << 16) | (fr << 8) | fl);
  endfunction

  function automatic logic [31:0] expData(input int ch, input logic [31:0] p, input bit first);
    logic [31:0] r;
    r = p;
    if (TagEn && first) r[31:26] = 6'(ch);
    return r;
  endfunction

  task automatic addFrame(input int ch, input int fr, input int n);
    for (int i = 0; i < n; i++) begin
      qData[ch].push_back(payload(ch, fr, i));
      qEofc[ch].push_back((i == n - 1) ? 8'd4 : 8'd0);
    end
  endtask

  task automatic appendExp(input int ch, input int fr, input int n);
    for (int i = 0; i < n; i++) begin
      expD.push_back(expData(ch, payload(ch, fr, i), i == 0));
      expE.push_back((i == n - 1) ? 8'd4 : 8'd0);
    end
  endtask

  // One clock: drive sources at negedge, sample just before posedge, pop after
  task automatic applyStimulus();
    logic [NC-1:0] acc;
    @(negedge clk);
    outStop = outStopNext;
    for (int c = 0; c < NC; c++) begin
      if (chEn[c] && qData[c].size() > 0) begin
        inReady[c]          = 1'b1;
        inData[c*DW +: DW]  = qData[c][0];
        inEofc[c*8 +: 8]    = qEofc[c][0];
      end else begin
        inReady[c]          = 1'b0;
        inData[c*DW +: DW]  = '0;
        inEofc[c*8 +: 8]    = '0;
      end
    end
    #4;
    for (int c = 0; c < NC; c++) acc[c] = inReady[c] && !curStop[c];
    if (curOutReady && !outStop) begin
      obsData.push_back(curOutData);
      obsEofc.push_back(curOutEofc);
      obsCyc.push_back(cycleNo);
    end
    @(posedge clk);
    for (int c = 0; c < NC; c++) begin
      if (acc[c]) begin
        void'(qData[c].pop_front());
        void'(qEofc[c].pop_front());
      end
    end
    cycleNo++;
  endtask

  task automatic runUntil(input int n, input int budget);
    int k;
    k = 0;
    while (obsData.size() < n && k < budget) begin
      applyStimulus();
      k++;
    end
  endtask

  task automatic resetAll(input int dut);
    activeDut = dut;
    for (int c = 0; c < NC; c++) begin
      qData[c].delete();
      qEofc[c].delete();
    end
    chEn        = '1;
    outStopNext = 1'b0;
    @(negedge clk);
    rst_n   = 1'b0;
    inReady = '0;
    inEofc  = '0;
    inData  = '0;
    outStop = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    obsData.delete(); obsEofc.delete(); obsCyc.delete();
    expD.delete(); expE.delete();
    cycleNo = 0;
  endtask

  // Reset values with every input active, then first grant after release
  task automatic test_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    inReady = '1;
    inEofc  = {NC{8'h04}};
    inData  = '1;
    outStop = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      activeDut = d;
      #1;
      checks++;
      if (curOutReady !== 1'b0) begin
        failures++; $display("[TB] FAIL reset_out_ready dut=%0d actual=%b required=0", d, curOutReady);
      end
      checks++;
      if (curStop !== 4'hF) begin
        failures++; $display("[TB] FAIL reset_in_stop dut=%0d actual=%h required=f", d, curStop);
      end
      checks++;
      if (curOutEofc !== 8'd0 || curOutData !== 32'd0 || curGrant !== 4'd0) begin
        failures++;
        $display("[TB] FAIL reset_regs dut=%0d actual=%h/%h/%h required=0/0/0", d, curOutEofc, curOutData, curGrant);
      end
    end
    inReady = 4'b0100;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      activeDut = d;
      #1;
      checks++;
      if (curGrant !== 4'd2) begin
        failures++; $display("[TB] FAIL reset_first_grant dut=%0d actual=%0d required=2", d, curGrant);
      end
    end
  endtask

  // Four channels with 3-flit frames: order 0,1,2,3,0 and one idle cycle between frames
  task automatic test_round_robin();
    resetAll(0);
    addFrame(0, 0, 3); addFrame(0, 1, 3);
    addFrame(1, 0, 3); addFrame(2, 0, 3); addFrame(3, 0, 3);
    appendExp(0, 0, 3); appendExp(1, 0, 3); appendExp(2, 0, 3);
    appendExp(3, 0, 3); appendExp(0, 1, 3);
    runUntil(15, 200);
    checks++;
    if (obsData.size() !== 15) begin
      failures++; $display("[TB] FAIL rr_count actual=%0d required=15", obsData.size());
    end
    for (int i = 0; i < expD.size(); i++) begin
      checks++;
      if (i >= obsData.size()) begin
        failures++; $display("[TB] FAIL rr_flit idx=%0d actual=missing required=%h", i, expD[i]);
      end else if (obsData[i] !== expD[i] || obsEofc[i] !== expE[i]) begin
        failures++;
        $display("[TB] FAIL rr_flit idx=%0d actual=%h/%h required=%h/%h", i, obsData[i], obsEofc[i], expD[i], expE[i]);
      end
    end
    for (int i = 1; i < obsCyc.size(); i++) begin
      checks++;
      if (obsCyc[i] - obsCyc[i-1] !== ((i % 3 == 0) ? 2 : 1)) begin
        failures++;
        $display("[TB] FAIL rr_spacing idx=%0d actual=%0d required=%0d", i, obsCyc[i] - obsCyc[i-1], (i % 3 == 0) ? 2 : 1);
      end
    end
  endtask

  // Burst of three single-flit frames, then channel 3, then channel 1 resumes
  task automatic test_burst();
    resetAll(1);
    for (int f = 0; f < 5; f++) addFrame(1, f, 1);
    addFrame(3, 0, 1);
    appendExp(1, 0, 1); appendExp(1, 1, 1); appendExp(1, 2, 1);
    appendExp(3, 0, 1); appendExp(1, 3, 1); appendExp(1, 4, 1);
    runUntil(6, 200);
    for (int i = 0; i < expD.size(); i++) begin
      checks++;
      if (i >= obsData.size()) begin
        failures++; $display("[TB] FAIL burst_flit idx=%0d actual=missing required=%h", i, expD[i]);
      end else if (obsData[i] !== expD[i] || obsEofc[i] !== expE[i]) begin
        failures++;
        $display("[TB] FAIL burst_flit idx=%0d actual=%h/%h required=%h/%h", i, obsData[i], obsEofc[i], expD[i], expE[i]);
      end
    end
  endtask

  // Channel 1 stops requesting after one frame: HOLD forfeits to channel 3
  task automatic test_burst_forfeit();
    resetAll(1);
    addFrame(1, 0, 1);
    addFrame(3, 0, 2);
    appendExp(1, 0, 1); appendExp(3, 0, 2);
    runUntil(3, 100);
    for (int i = 0; i < expD.size(); i++) begin
      checks++;
      if (i >= obsData.size()) begin
        failures++; $display("[TB] FAIL forfeit_flit idx=%0d actual=missing required=%h", i, expD[i]);
      end else if (obsData[i] !== expD[i] || obsEofc[i] !== expE[i]) begin
        failures++;
        $display("[TB] FAIL forfeit_flit idx=%0d actual=%h/%h required=%h/%h", i, obsData[i], obsEofc[i], expD[i], expE[i]);
      end
    end
  endtask

  // Downstream stop for five cycles in the middle of a 6-flit frame
  task automatic test_backpressure();
    logic [31:0] refData;
    logic [7:0]  refEofc;
    resetAll(0);
    addFrame(2, 0, 6);
    appendExp(2, 0, 6);
    runUntil(2, 60);
    checks++;
    if (obsData.size() !== 2) begin
      failures++; $display("[TB] FAIL bp_start actual=%0d required=2", obsData.size());
    end
    outStopNext = 1'b1;
    applyStimulus();
    #1;
    refData = curOutData;
    refEofc = curOutEofc;
    checks++;
    if (refData !== expD[2] || refEofc !== expE[2]) begin
      failures++; $display("[TB] FAIL bp_held_flit actual=%h/%h required=%h/%h", refData, refEofc, expD[2], expE[2]);
    end
    repeat (4) begin
      applyStimulus();
      #1;
      checks++;
      if (curOutReady !== 1'b1 || curOutData !== refData || curOutEofc !== refEofc) begin
        failures++;
        $display("[TB] FAIL bp_stable actual=%b/%h/%h required=1/%h/%h", curOutReady, curOutData, curOutEofc, refData, refEofc);
      end
      checks++;
      if (curStop[2] !== 1'b1) begin
        failures++; $display("[TB] FAIL bp_in_stop actual=%b required=1", curStop[2]);
      end
    end
    checks++;
    if (obsData.size() !== 2) begin
      failures++; $display("[TB] FAIL bp_no_transfer actual=%0d required=2", obsData.size());
    end
    outStopNext = 1'b0;
    runUntil(6, 40);
    repeat (4) applyStimulus();
    checks++;
    if (obsData.size() !== 6) begin
      failures++; $display("[TB] FAIL bp_count actual=%0d required=6", obsData.size());
    end
    for (int i = 0; i < expD.size(); i++) begin
      checks++;
      if (i >= obsData.size()) begin
        failures++; $display("[TB] FAIL bp_flit idx=%0d actual=missing required=%h", i, expD[i]);
      end else if (obsData[i] !== expD[i] || obsEofc[i] !== expE[i]) begin
        failures++;
        $display("[TB] FAIL bp_flit idx=%0d actual=%h/%h required=%h/%h", i, obsData[i], obsEofc[i], expD[i], expE[i]);
      end
    end
    for (int i = 3; i < obsCyc.size() && i < 6; i++) begin
      checks++;
      if (obsCyc[i] - obsCyc[i-1] !== 1) begin
        failures++; $display("[TB] FAIL bp_rate idx=%0d actual=%0d required=1", i, obsCyc[i] - obsCyc[i-1]);
      end
    end
  endtask

  // Fixed priority: channel 0 wins while it requests, channel 2 afterwards
  task automatic test_fixed_priority();
    resetAll(2);
    addFrame(0, 0, 2); addFrame(0, 1, 2);
    addFrame(2, 0, 2);
    appendExp(0, 0, 2); appendExp(0, 1, 2); appendExp(2, 0, 2);
    runUntil(6, 100);
    for (int i = 0; i < expD.size(); i++) begin
      checks++;
      if (i >= obsData.size()) begin
        failures++; $display("[TB] FAIL fp_flit idx=%0d actual=missing required=%h", i, expD[i]);
      end else if (obsData[i] !== expD[i] || obsEofc[i] !== expE[i]) begin
        failures++;
        $display("[TB] FAIL fp_flit idx=%0d actual=%h/%h required=%h/%h", i, obsData[i], obsEofc[i], expD[i], expE[i]);
      end
    end
  endtask

  // All-ones 2-flit frame on channel 3: tag lands only in the first flit
  task automatic test_tag();
    resetAll(0);
    qData[3].push_back(32'hFFFF_FFFF); qEofc[3].push_back(8'd0);
    qData[3].push_back(32'hFFFF_FFFF); qEofc[3].push_back(8'd4);
    expD.push_back(TagEn ? 32'h0FFF_FFFF : 32'hFFFF_FFFF); expE.push_back(8'd0);
    expD.push_back(32'hFFFF_FFFF);                          expE.push_back(8'd4);
    runUntil(2, 40);
    for (int i = 0; i < expD.size(); i++) begin
      checks++;
      if (i >= obsData.size()) begin
        failures++; $display("[TB] FAIL tag_flit idx=%0d actual=missing required=%h", i, expD[i]);
      end else if (obsData[i] !== expD[i] || obsEofc[i] !== expE[i]) begin
        failures++;
        $display("[TB] FAIL tag_flit idx=%0d actual=%h/%h required=%h/%h", i, obsData[i], obsEofc[i], expD[i], expE[i]);
      end
    end
  endtask

  // Test sequence
  initial begin
    checks      = 0;
    failures    = 0;
    cycleNo     = 0;
    activeDut   = 0;
    chEn        = '1;
    outStopNext = 1'b0;
    rst_n       = 1'b0;
    inReady     = '0;
    inEofc      = '0;
    inData      = '0;
    outStop     = 1'b0;
    $display("[TB] starting smi_frame_arbiter_xn tests (tag insert %0d)", TagEn);
    test_reset();
    test_round_robin();
    test_burst();
    test_burst_forfeit();
    test_backpressure();
    test_fixed_priority();
    test_tag();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
